uart_rx_buf: RTL

Receive half of the board serial link: deserialises 8N1 frames arriving on the `Rx` pin of `riscv_top` and buffers them in a FIFO for the CPU-side I/O controller. It completes the host-to-CPU direction, alongside the existing CPU-to-host `Tx` path. The same block runs on the FPGA and under simulation, where the testbench drives `Rx` with a bit-banged host model.

---
 rtl/uart_rx_buf_pkg.sv | 16 +
 rtl/uart_rx_buf_fifo.sv | 58 +++++
 rtl/uart_rx_buf.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_buf_pkg.sv
// Shared definitions for the UART receive path: FSM encodings and 8N1 frame constants.
package uart_rx_buf_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int STOP_BITS  = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_buf_fifo.sv
// First-word fall-through FIFO with occupancy count; head reads as zero while empty.
module uart_fifo #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic              pop_ok;
  logic              wr_ok;

  assign empty  = (cnt == '0);
  assign full   = (cnt == (ADDR_W+1)'(DEPTH));
  assign count  = cnt;
  assign pop_ok = rd_en && !empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_ok  = wr_en && (!full || pop_ok);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with 16x oversampling, feeding a FWFT byte FIFO.
module uart_rx_buf
  import uart_rx_buf_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            frame_err,
  output logic            overflow
);

  function automatic int sat_div(input int clk_hz, input int baud);
    int d;
    d = clk_hz / (baud * OVERSAMPLE);
    if (d < 1)
      d = 1;
    return d;
  endfunction

  localparam int DIV   = sat_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [3:0] SC_MID  = 4'(OVERSAMPLE/2 - 1);
  localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BI_LAST = 3'(DATA_BITS - 1);

  logic             rx_p0;
  logic             rx_p1;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  rx_state_t        state, state_n;
  logic [3:0]       sc, sc_n;
  logic [2:0]       bi, bi_n;
  logic [7:0]       shreg, shreg_n;
  logic             start_det;
  logic             push;
  logic             ferr_n;
  logic             ovf_n;

  // Stage p0/p1: two-flop synchroniser, idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt <= '0;
    else if (start_det || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sc        <= '0;
      bi        <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_n;
      sc        <= sc_n;
      bi        <= bi_n;
      frame_err <= ferr_n;
      overflow  <= ovf_n;
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_n;
  end

  always_comb begin
    state_n   = state;
    sc_n      = sc;
    bi_n      = bi;
    shreg_n   = shreg;
    start_det = 1'b0;
    push      = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_p1) begin
          state_n   = ST_START;
          sc_n      = '0;
          start_det = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sc == SC_MID) begin
            // Still low at mid start bit: genuine frame, re-phase to bit centres.
            if (!rx_p1) begin
              state_n = ST_DATA;
              sc_n    = '0;
              bi_n    = '0;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            sc_n = sc + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == SC_LAST) begin
            shreg_n = {rx_p1, shreg[7:1]};
            bi_n    = bi + 3'd1;
            if (bi == BI_LAST)
              state_n = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == SC_LAST) begin
            if (rx_p1) begin
              push    = 1'b1;
              state_n = ST_IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = ST_BREAK;
            end
          end
        end
      end
      ST_BREAK: begin
        if (rx_p1)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so only an unserviced full FIFO drops.
  assign ovf_n = push && full && !rd_en;

  uart_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (shreg),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule
